// File: rtl/dota_share_scheduler.sv
// Shares one digital OTA/comparator cell between NCH analog input pairs:
// round-robin arbitration, settle wait, NSAMP-sample majority conversion.
module dota_share_scheduler #(
    parameter int NCH    = 4,
    parameter int SETTLE = 8,
    parameter int NSAMP  = 4,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CW    = $clog2(NSAMP + 1),
    localparam int CNTMAX = (SETTLE > NSAMP) ? SETTLE : NSAMP,
    localparam int CNTW  = (CNTMAX > 1) ? $clog2(CNTMAX) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           ota_out,
    output logic [CHW-1:0] sel,
    output logic           ota_en,
    output logic [NCH-1:0] gnt,
    output logic           busy,
    output logic [NCH-1:0] done,
    output logic           res_valid,
    output logic [CHW-1:0] res_ch,
    output logic [CW-1:0]  res_ones,
    output logic           res_bit
);

    // Handshake: a requester raises req[i] and holds it until done[i] pulses;
    // gnt[i] is asserted from the grant cycle through the DONE cycle, and
    // res_valid marks the single cycle in which res_* belong to that grant.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic           sync1;
    logic           ota_s;
    logic [CNTW-1:0] cnt;
    logic [CW-1:0]  ones;
    logic [CW-1:0]  ones_nx;
    logic [CHW-1:0] last;
    logic           pick_valid;
    logic [CHW-1:0] pick_idx;
    logic           settle_end;
    logic           sample_end;

    // ota_out is asynchronous to clk; only the second flop is ever observed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            ota_s <= 1'b0;
        end else begin
            sync1 <= ota_out;
            ota_s <= sync1;
        end
    end

    // Round-robin scan last+1, last+2, ...; the smallest offset wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(last) + k) % NCH;
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = CHW'(idx);
            end
        end
    end

    assign settle_end = (cnt == CNTW'(SETTLE - 1));
    assign sample_end = (cnt == CNTW'(NSAMP - 1));
    assign ones_nx    = ones + CW'(ota_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (pick_valid) state_nx = S_SETTLE;
            S_SETTLE: if (settle_end) state_nx = S_SAMPLE;
            S_SAMPLE: if (sample_end) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ones      <= '0;
            last      <= CHW'(NCH - 1);
            sel       <= '0;
            gnt       <= '0;
            ota_en    <= 1'b0;
            done      <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_ones  <= '0;
            res_bit   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt    <= {{(NCH-1){1'b0}}, 1'b1} << pick_idx;
                        sel    <= pick_idx;
                        ota_en <= 1'b1;
                        cnt    <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_end) begin
                        cnt  <= '0;
                        ones <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    ones <= ones_nx;
                    cnt  <= cnt + 1'b1;
                    // Results land together with the DONE state so res_valid
                    // and done are coincident with the registered result.
                    if (sample_end) begin
                        done      <= gnt;
                        res_valid <= 1'b1;
                        res_ch    <= sel;
                        res_ones  <= ones_nx;
                        res_bit   <= ((int'(ones_nx) * 2) > NSAMP);
                    end
                end
                S_DONE: begin
                    done      <= '0;
                    res_valid <= 1'b0;
                    last      <= sel;
                    ota_en    <= 1'b0;
                    gnt       <= '0;
                end
                default: begin
                    gnt    <= '0;
                    ota_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dota_share_scheduler.sv
// Directed bench for dota_share_scheduler with default parameters
// (NCH=4, SETTLE=8, NSAMP=4): arbitration order, timing, sampling window, reset.
module tb_dota_share_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ota_out;
    logic [1:0] sel;
    logic       ota_en;
    logic [3:0] gnt;
    logic       busy;
    logic [3:0] done;
    logic       res_valid;
    logic [1:0] res_ch;
    logic [2:0] res_ones;
    logic       res_bit;

    int checks = 0;
    int errors = 0;

    dota_share_scheduler #(.NCH(4), .SETTLE(8), .NSAMP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ota_out   (ota_out),
        .sel       (sel),
        .ota_en    (ota_en),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_ones  (res_ones),
        .res_bit   (res_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"}, 32'(sel), 0);
        check({tag, "_ota_en"}, 32'(ota_en), 0);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_ch"}, 32'(res_ch), 0);
        check({tag, "_res_ones"}, 32'(res_ones), 0);
        check({tag, "_res_bit"}, 32'(res_bit), 0);
    endtask

    // Called at a negedge with the DUT idle. The grant edge G follows the
    // first negedge; samples use ota_out as seen at edges G+7..G+10.
    task automatic convert(input logic [3:0] req_v, input logic [3:0] req_mid,
                           input logic [3:0] req_end, input logic settle_v,
                           input logic [3:0] pat, input int ch, input int ones,
                           input logic bit_v);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        req = req_v;
        ota_out = settle_v;
        @(negedge clk);
        check("grant_sel", 32'(sel), ch);
        check("grant_gnt", 32'(gnt), 32'(oh));
        check("grant_ota_en", 32'(ota_en), 1);
        check("grant_busy", 32'(busy), 1);
        req = req_mid;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ota_out = pat[i];
            @(negedge clk);
        end
        ota_out = 1'b1;
        @(negedge clk);
        check("pre_done_res_valid", 32'(res_valid), 0);
        check("pre_done_gnt", 32'(gnt), 32'(oh));
        @(negedge clk);
        check("done_res_valid", 32'(res_valid), 1);
        check("done_onehot", 32'(done), 32'(oh));
        check("done_res_ch", 32'(res_ch), ch);
        check("done_res_ones", 32'(res_ones), ones);
        check("done_res_bit", 32'(res_bit), 32'(bit_v));
        check("done_ota_en", 32'(ota_en), 1);
        check("done_gnt", 32'(gnt), 32'(oh));
        req = req_end;
        @(negedge clk);
        check("post_res_valid", 32'(res_valid), 0);
        check("post_done", 32'(done), 0);
        check("post_ota_en", 32'(ota_en), 0);
        check("post_gnt", 32'(gnt), 0);
        check("post_busy", 32'(busy), 0);
        check("hold_res_ch", 32'(res_ch), ch);
        check("hold_res_ones", 32'(res_ones), ones);
        check("hold_res_bit", 32'(res_bit), 32'(bit_v));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        ota_out = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Single request, constant 1 on the OTA.
        convert(4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b1111, 2, 4, 1'b1);

        // Tie resolves to 0; three of four is a majority.
        convert(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0011, 0, 2, 1'b0);
        convert(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0111, 1, 3, 1'b1);

        // Settle values must not leak into the ones-count.
        convert(4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000, 3, 0, 1'b0);

        // Request dropped during SETTLE still completes once.
        convert(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b1101, 2, 3, 1'b1);
        @(negedge clk);
        check("drop_no_regrant_busy", 32'(busy), 0);
        check("drop_no_repeat_done", 32'(done), 0);

        // All channels held after reset: 0,1,2,3,0 back to back.
        rst = 1'b1;
        #1;
        check("rst2_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        convert(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b1111, 0, 4, 1'b1);
        convert(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0011, 1, 2, 1'b0);
        convert(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0111, 2, 3, 1'b1);
        convert(4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0000, 3, 0, 1'b0);
        convert(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0001, 0, 1, 1'b0);

        // Fairness: ch0 held, ch3 raised during ch0's conversion wins next.
        convert(4'b0001, 4'b1001, 4'b1001, 1'b0, 4'b1000, 0, 1, 1'b0);
        convert(4'b1001, 4'b1001, 4'b0001, 1'b0, 4'b1110, 3, 3, 1'b1);
        convert(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b1100, 0, 2, 1'b0);

        // Reset mid-SAMPLE: outputs clear at once and ch0 wins over the
        // round-robin position left by ch1.
        convert(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b1111, 1, 4, 1'b1);
        req = 4'b0100;
        ota_out = 1'b1;
        @(negedge clk);
        check("rst_pre_sel", 32'(sel), 2);
        repeat (10) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_sample");
        @(negedge clk);
        check("rst_hold_busy", 32'(busy), 0);
        rst = 1'b0;
        convert(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b1011, 0, 3, 1'b1);

        repeat (3) @(negedge clk);
        check("final_idle_busy", 32'(busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dota_share_scheduler.md
Name: dota_share_scheduler

Overview: Time-multiplexes the single digital OTA/comparator cell between NCH analog input pairs. Arbitrates channel requests round-robin, drives the analog mux select and the OTA enable, waits a settle interval, then samples the synchronised OTA output NSAMP times. Reports a per-channel ones-count and majority decision. Sits between the OTA macro (ua-side mux and OTA) and the digital readout logic.

Parameters:
NCH, 4, number of requesting input channels (2..8)
SETTLE, 8, cycles from mux switch to first sample; includes the 2-cycle synchroniser latency (must be >= 2)
NSAMP, 4, OTA samples accumulated per conversion (1..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  NCH  level request per channel; held by the requester until its done pulse
ota_out  input  1  raw OTA output; asynchronous to clk
sel  output  CHW  analog mux select, CHW = max(1, clog2(NCH))
ota_en  output  1  OTA enable; low in IDLE to save power
gnt  output  NCH  one-hot grant; stable from grant until DONE
busy  output  1  high in any state other than IDLE
done  output  NCH  one-cycle completion pulse, one-hot for the served channel
res_valid  output  1  one-cycle pulse, coincident with done
res_ch  output  CHW  channel index of the last result
res_ones  output  CW  ones-count of the last conversion, CW = clog2(NSAMP+1)
res_bit  output  1  majority decision of the last conversion

Behaviour:
- Reset (async assert):
  - All outputs go to 0 immediately; state goes to IDLE.
  - Synchroniser flops are cleared.
  - Round-robin pointer last is set to NCH-1, so channel 0 has first priority.
- Reset release is synchronous to clk.
- ota_out passes through a 2-flop synchroniser (ota_s). Only ota_s is used internally.
- State IDLE:
  - ota_en=0 and gnt=0.
  - If any req is high, pick the first set bit scanning last+1, last+2, ... (modulo NCH).
  - Register gnt and sel, set ota_en=1, clear cnt, and go to SETTLE.
  - Requests are evaluated with a one-cycle decision.
- State SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE-1, clear cnt and ones, and go to SAMPLE.
  - SETTLE therefore lasts exactly SETTLE cycles. ota_s is ignored during SETTLE.
- State SAMPLE:
  - Each cycle, ones += ota_s and cnt increments.
  - When cnt==NSAMP-1, go to DONE. The final sample is included.
  - Exactly NSAMP samples are taken.
- State DONE (one cycle):
  - res_valid=1 and done[g]=1.
  - res_ch, res_ones and res_bit are registered.
  - last <= g, ota_en <= 0, gnt <= 0, then go to IDLE.
- res_bit = 1 iff 2*ones > NSAMP; a tie resolves to 0.
- res_ch, res_ones and res_bit hold their values until the next DONE.
- Latency: req sampled in IDLE at cycle t gives sel valid at t+1 and res_valid at t+1+SETTLE+NSAMP.
- Minimum gap between conversions is 1 IDLE cycle. The next grant is registered on the cycle after DONE.
- A req deasserted after grant does not abort: the conversion completes and done still pulses.
- A req still high after its done re-enters arbitration, but at lowest priority.
- Simultaneous requests resolve strictly by the round-robin order above. No channel waits more than NCH-1 conversions.
- ones width is CW. It cannot overflow because ones is at most NSAMP.
- sel is don't-care when gnt=0; it holds its last value.

Test Plan:
- Single request, defaults: req=0100, ota_out=1 constant -> sel=2 at t+1, ota_en=1, res_valid at t+13 with res_ch=2, res_ones=4, res_bit=1, done=0100; ota_en=0 the following cycle.
- All requests held (req=1111) after reset -> channels served in order 0,1,2,3,0; each res_valid separated by 14 cycles.
- Tie pattern: ota_s=1,1,0,0 across the four SAMPLE cycles -> res_ones=2, res_bit=0. Pattern 1,1,1,0 -> res_ones=3, res_bit=1.
- Settle masking: ota_out=1 throughout SETTLE, then 0 from 2 cycles before SAMPLE -> res_ones=0, res_bit=0.
- Mid-operation events:
  - Drop req during SETTLE -> conversion still completes and done pulses once.
  - Assert rst during SAMPLE -> all outputs are 0 in the same cycle, IDLE follows, and the next grant goes to channel 0.
- Fairness: req[0] held high and req[3] raised once -> ch3 is served no later than the second conversion after its assertion.
